axil_mem_slave: RTL and testbench

AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

---
 rtl/axil_pkg.sv | 10 +
 rtl/axil_mem_array.sv | 28 ++
 rtl/axil_mem_slave.sv | 150 +++++++++++++++
 tb/tb_axil_mem_slave.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite memory slave definitions: response codes and FSM encodings.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;
  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_e;

endpackage

// File: rtl/axil_mem_array.sv
// DEPTH x DATAWIDTH storage: one byte-enabled write port, one asynchronous read port.
module axil_mem_array #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 32
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATAWIDTH-1:0]       wdata,
  input  logic [DATAWIDTH/8-1:0]     wstrb,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATAWIDTH-1:0]       rdata
);
  localparam int NB = DATAWIDTH / 8;

  // Contents are deliberately not reset.
  logic [NB-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++)
        if (wstrb[b]) mem[waddr][b] <= wdata[b*8 +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axil_mem_slave.sv
// AXI4-Lite slave backed by a byte-enabled word array; independent read and write FSMs.
module axil_mem_slave import axil_pkg::*; #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32,
  parameter int DEPTH     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRWIDTH-1:0]   AWADDR,
  input  logic [2:0]             AWPROT,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [DATAWIDTH-1:0]   WDATA,
  input  logic [DATAWIDTH/8-1:0] WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  input  logic [ADDRWIDTH-1:0]   ARADDR,
  input  logic [2:0]             ARPROT,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [DATAWIDTH-1:0]   RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY
);
  localparam int NB  = DATAWIDTH / 8;
  localparam int OFS = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int HI  = OFS + IW;

  function automatic logic oor(input logic [ADDRWIDTH-1:0] a);
    return (a >> HI) != '0;
  endfunction

  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  wr_state_e              wstate;
  rd_state_e              rstate;
  logic                   aw_got, w_got;
  logic [ADDRWIDTH-1:0]   awaddr_q;
  logic [DATAWIDTH-1:0]   wdata_q;
  logic [NB-1:0]          wstrb_q;
  logic                   aw_hs, w_hs, commit, mem_we;
  logic [ADDRWIDTH-1:0]   wr_addr;
  logic [DATAWIDTH-1:0]   wr_data, mem_rdata;
  logic [NB-1:0]          wr_strb;

  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  // A channel arriving this cycle bypasses its capture register so commit can happen on the same edge.
  assign wr_addr = aw_got ? awaddr_q : AWADDR;
  assign wr_data = w_got  ? wdata_q  : WDATA;
  assign wr_strb = w_got  ? wstrb_q  : WSTRB;
  assign commit  = (wstate == W_IDLE) & (aw_got | aw_hs) & (w_got | w_hs);
  assign mem_we  = commit & ~oor(wr_addr);

  axil_mem_array #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr[HI-1:OFS]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .raddr (ARADDR[HI-1:OFS]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate   <= W_IDLE;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BRESP    <= RESP_OKAY;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (commit) begin
            wstate  <= W_RESP;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= oor(wr_addr) ? RESP_SLVERR : RESP_OKAY;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
          end else begin
            AWREADY <= ~(aw_got | aw_hs);
            WREADY  <= ~(w_got | w_hs);
            if (aw_hs) begin
              aw_got   <= 1'b1;
              awaddr_q <= AWADDR;
            end
            if (w_hs) begin
              w_got   <= 1'b1;
              wdata_q <= WDATA;
              wstrb_q <= WSTRB;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            wstate  <= W_IDLE;
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate  <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RRESP   <= RESP_OKAY;
      RDATA   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          ARREADY <= 1'b1;
          if (ARVALID && ARREADY) begin
            rstate  <= R_DATA;
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RRESP   <= oor(ARADDR) ? RESP_SLVERR : RESP_OKAY;
            RDATA   <= oor(ARADDR) ? '0 : mem_rdata;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            rstate  <= R_IDLE;
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_mem_slave.sv
// Directed bench: vector table for single transfers plus hand sequences for reset, stalls and 64-bit lanes.
module tb_axil_mem_slave;
  import axil_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  logic [31:0] d_awaddr, d_araddr;
  logic [63:0] d_wdata, d_rdata;
  logic [7:0]  d_wstrb;
  logic        d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
  logic        d_arvalid, d_arready, d_rvalid, d_rready;
  logic [1:0]  d_bresp, d_rresp;

  axil_mem_slave #(.DATAWIDTH(32), .ADDRWIDTH(32), .DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  axil_mem_slave #(.DATAWIDTH(64), .ADDRWIDTH(32), .DEPTH(32)) dut64 (
    .clk(clk), .rst(rst),
    .AWADDR(d_awaddr), .AWPROT(3'b000), .AWVALID(d_awvalid), .AWREADY(d_awready),
    .WDATA(d_wdata), .WSTRB(d_wstrb), .WVALID(d_wvalid), .WREADY(d_wready),
    .BRESP(d_bresp), .BVALID(d_bvalid), .BREADY(d_bready),
    .ARADDR(d_araddr), .ARPROT(3'b000), .ARVALID(d_arvalid), .ARREADY(d_arready),
    .RDATA(d_rdata), .RRESP(d_rresp), .RVALID(d_rvalid), .RREADY(d_rready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    int          hold;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic axi_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int lead, input logic [1:0] exp_resp);
    bit aw_hs, w_hs;
    int ld;
    ld = lead;
    @(negedge clk);
    WDATA = d; WSTRB = s; WVALID = 1'b1; AWADDR = a;
    if (ld == 0) AWVALID = 1'b1;
    for (int c = 0; c < 50 && (AWVALID || WVALID || ld > 0); c++) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(negedge clk);
      if (aw_hs) AWVALID = 1'b0;
      if (w_hs)  WVALID  = 1'b0;
      if (ld > 0 && !WVALID) begin
        ld--;
        if (ld == 0) AWVALID = 1'b1;
      end
    end
    chk({nm, "_hs_timeout"}, {62'd0, AWVALID, WVALID}, 64'd0);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk({nm, "_bvalid"}, BVALID, 1);
    chk({nm, "_bresp"}, BRESP, exp_resp);
    @(negedge clk);
    chk({nm, "_bdrop"}, {62'd0, BVALID, AWREADY}, 64'd1);
  endtask

  task automatic axi_read(input string nm, input logic [31:0] a, input int hold,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    @(negedge clk);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b0;
    for (int c = 0; c < 20 && !ARREADY; c++) @(negedge clk);
    chk({nm, "_arready"}, ARREADY, 1);
    @(negedge clk);
    ARVALID = 1'b0;
    chk({nm, "_rvalid"}, RVALID, 1);
    chk({nm, "_rdata"}, RDATA, exp_data);
    chk({nm, "_rresp"}, RRESP, exp_resp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_rvalid"}, RVALID, 1);
      chk({nm, "_hold_rdata"}, RDATA, exp_data);
      chk({nm, "_hold_arready"}, ARREADY, 0);
    end
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    chk({nm, "_rdrop"}, {62'd0, RVALID, ARREADY}, 64'd1);
  endtask

  task automatic w64(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    @(negedge clk);
    d_awaddr = a; d_wdata = d; d_wstrb = s; d_awvalid = 1'b1; d_wvalid = 1'b1;
    for (int c = 0; c < 20 && !(d_awready && d_wready); c++) @(negedge clk);
    chk("w64_ready", {62'd0, d_awready, d_wready}, 64'd3);
    @(negedge clk);
    d_awvalid = 1'b0; d_wvalid = 1'b0;
    chk("w64_bvalid", d_bvalid, 1);
    chk("w64_bresp", d_bresp, RESP_OKAY);
    @(negedge clk);
  endtask

  task automatic r64(input logic [31:0] a, input logic [63:0] exp);
    @(negedge clk);
    d_araddr = a; d_arvalid = 1'b1; d_rready = 1'b1;
    for (int c = 0; c < 20 && !d_arready; c++) @(negedge clk);
    chk("r64_arready", d_arready, 1);
    @(negedge clk);
    d_arvalid = 1'b0;
    chk("r64_rvalid", d_rvalid, 1);
    chk("r64_rdata", d_rdata, exp);
    chk("r64_rresp", d_rresp, RESP_OKAY);
    @(negedge clk);
    d_rready = 1'b0;
  endtask

  initial begin
    vecs = '{
      '{1'b1, 32'h0000_0000, 32'h0123_4567, 4'hF, 0, 0, 32'h0,         RESP_OKAY},
      '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0, 32'h0,         RESP_OKAY},
      '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 32'hDEAD_BEEF, RESP_OKAY},
      '{1'b1, 32'h0000_000C, 32'h1122_3344, 4'hF, 0, 0, 32'h0,         RESP_OKAY},
      '{1'b1, 32'h0000_000C, 32'h0000_AAAA, 4'h3, 3, 0, 32'h0,         RESP_OKAY},
      '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 0, 0, 32'h1122_AAAA, RESP_OKAY},
      '{1'b0, 32'h0000_000E, 32'h0,         4'h0, 0, 0, 32'h1122_AAAA, RESP_OKAY},
      '{1'b1, 32'h0000_007C, 32'h55AA_55AA, 4'hF, 0, 0, 32'h0,         RESP_OKAY},
      '{1'b1, 32'h0000_007C, 32'h0000_0000, 4'h0, 0, 0, 32'h0,         RESP_OKAY},
      '{1'b0, 32'h0000_007C, 32'h0,         4'h0, 0, 5, 32'h55AA_55AA, RESP_OKAY},
      '{1'b0, 32'h0000_0080, 32'h0,         4'h0, 0, 0, 32'h0,         RESP_SLVERR},
      '{1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 4'hF, 0, 0, 32'h0,         RESP_SLVERR},
      '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 0, 32'h0123_4567, RESP_OKAY},
      '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 32'hDEAD_BEEF, RESP_OKAY},
      '{1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 0, 0, 32'h0,         RESP_OKAY},
      '{1'b1, 32'h0000_0010, 32'h0011_0000, 4'h4, 0, 0, 32'h0,         RESP_OKAY},
      '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 32'hA511_A5A5, RESP_OKAY},
      '{1'b0, 32'h1000_0000, 32'h0,         4'h0, 0, 0, 32'h0,         RESP_SLVERR},
      '{1'b1, 32'h1000_0010, 32'h1234_5678, 4'hF, 0, 0, 32'h0,         RESP_SLVERR},
      '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 32'hA511_A5A5, RESP_OKAY}
    };

    AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 1;
    ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 0;
    d_awaddr = '0; d_awvalid = 0; d_wdata = '0; d_wstrb = '0; d_wvalid = 0; d_bready = 1;
    d_araddr = '0; d_arvalid = 0; d_rready = 0;

    // Reset state and ready release timing
    #12;
    chk("rst_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
    chk("rst_valid", {62'd0, BVALID, RVALID}, 64'd0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_resp", {60'd0, BRESP, RRESP}, 64'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("rel_ready_early", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
    @(negedge clk);
    chk("rel_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);

    foreach (vecs[i]) begin
      if (vecs[i].wr)
        axi_write($sformatf("v%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb,
                  vecs[i].lead, vecs[i].exp_resp);
      else
        axi_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].hold,
                 vecs[i].exp_data, vecs[i].exp_resp);
    end

    // Reset while a write response is pending
    BREADY = 1'b0;
    @(negedge clk);
    AWADDR = 32'h14; WDATA = 32'h0000_0077; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("pend_bvalid", BVALID, 1);
    #2 rst = 1'b0; #1;
    chk("midrst_ready", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
    chk("midrst_valid", {62'd0, BVALID, RVALID}, 64'd0);
    chk("midrst_rdata", RDATA, 0);
    BREADY = 1'b1;
    @(negedge clk); rst = 1'b1; #1;
    chk("midrst_ready_early", {61'd0, AWREADY, WREADY, ARREADY}, 64'd0);
    @(negedge clk);
    chk("midrst_ready_back", {61'd0, AWREADY, WREADY, ARREADY}, 64'd7);

    // Reset with only AW captured: nothing may be written, capture must be forgotten
    AWADDR = 32'h08; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    chk("aw_only_awready", AWREADY, 0);
    #2 rst = 1'b0; #3;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    axi_write("post_rst_wr", 32'h18, 32'h0000_0099, 4'hF, 0, RESP_OKAY);
    axi_read("keep14", 32'h14, 0, 32'h0000_0077, RESP_OKAY);
    axi_read("keep08", 32'h08, 0, 32'hDEAD_BEEF, RESP_OKAY);
    axi_read("new18", 32'h18, 0, 32'h0000_0099, RESP_OKAY);

    // Same-edge write commit and read capture to one address
    @(negedge clk);
    AWADDR = 32'h08; WDATA = 32'h5555_0000; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 32'h08; ARVALID = 1'b1; RREADY = 1'b0;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("same_edge_rdata", RDATA, 32'hDEAD_BEEF);
    chk("same_edge_bvalid", BVALID, 1);
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    axi_read("after_same_edge", 32'h08, 0, 32'h5555_0000, RESP_OKAY);

    // 64-bit lanes: upper-half strobe leaves lower word intact
    w64(32'h10, 64'hAAAA_AAAA_BBBB_BBBB, 8'hFF);
    w64(32'h10, 64'h1234_5678_0000_0000, 8'hF0);
    r64(32'h10, 64'h1234_5678_BBBB_BBBB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
